// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window sequencer.
// Imported by the sequencer top level and its address generator.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int K_DEF  = 3;
    localparam int K_TAPS = K_DEF * K_DEF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SAT,
        HOLD,
        FIN
    } state_t;

endpackage

// File: rtl/conv_window_sequencer_addr_gen.sv
// Window/tap counters and image/weight address arithmetic.
// The FSM steps taps and windows; this block reports the last of each.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               tap_step,
    input  logic               win_step,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic               tap_first,
    output logic               last_tap,
    output logic               last_win,
    output logic [DATA_W-1:0]  row,
    output logic [DATA_W-1:0]  col
);

    localparam logic [WADDR_W-1:0] KM    = WADDR_W'(K - 1);
    localparam logic [WADDR_W-1:0] KW    = WADDR_W'(K);
    localparam logic [DATA_W-1:0]  COL_M = DATA_W'(IMG_W - K);
    localparam logic [DATA_W-1:0]  ROW_M = DATA_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0]  IW    = ADDR_W'(IMG_W);

    logic [WADDR_W-1:0] kx;
    logic [WADDR_W-1:0] ky;

    // Tap counters: kx fastest, wrap to tap 0 after the last tap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            kx <= '0;
            ky <= '0;
        end else if (tap_step) begin
            if (kx == KM) begin
                kx <= '0;
                ky <= (ky == KM) ? '0 : ky + 1'b1;
            end else begin
                kx <= kx + 1'b1;
            end
        end
    end

    // Window counters: raster order, wrap to (0,0) after the last window.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (win_step) begin
            if (col == COL_M) begin
                col <= '0;
                row <= (row == ROW_M) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Address multiply-add and end-of-sequence flags.
    always_comb begin
        img_addr  = (ADDR_W'(row) + ADDR_W'(ky)) * IW
                  + ADDR_W'(col) + ADDR_W'(kx);
        w_addr    = ky * KW + kx;
        tap_first = (kx == '0) && (ky == '0);
        last_tap  = (kx == KM) && (ky == KM);
        last_win  = (col == COL_M) && (row == ROW_M);
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequencer feeding the convolution MAC stage one window at a time.
// Holds the FSM, the tap-aligned control register and result tagging.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4,
    parameter int MAC_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  img_addr,
    input  logic [DATA_W-1:0]  img_data,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]  w_data,
    output logic [DATA_W-1:0]  signal,
    output logic [DATA_W-1:0]  weight,
    output logic               clken,
    output logic               s_convout,
    output logic               en_sat,
    output logic               en_mult_r,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_row,
    output logic [DATA_W-1:0]  out_col
);

    localparam logic [3:0] DL = 4'(MAC_LAT - 1);

    state_t            state;
    state_t            nstate;
    logic [3:0]        dcnt;
    logic              tap_first;
    logic              last_tap;
    logic              last_win;
    logic [DATA_W-1:0] row;
    logic [DATA_W-1:0] col;

    conv_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .K       (K),
        .ADDR_W  (ADDR_W),
        .WADDR_W (WADDR_W)
    ) u_addr (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .tap_step  (state == ISSUE),
        .win_step  (state == HOLD),
        .img_addr  (img_addr),
        .w_addr    (w_addr),
        .tap_first (tap_first),
        .last_tap  (last_tap),
        .last_win  (last_win),
        .row       (row),
        .col       (col)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = ISSUE;
            ISSUE:   if (last_tap) nstate = DRAIN;
            DRAIN:   if (dcnt == DL) nstate = SAT;
            SAT:     nstate = HOLD;
            HOLD:    nstate = last_win ? FIN : ISSUE;
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Drain cycle counter, cleared outside DRAIN.
    always_ff @(posedge clk) begin
        if (reset || state != DRAIN) dcnt <= '0;
        else                         dcnt <= dcnt + 1'b1;
    end

    // Controls delayed one cycle to line up with RAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            clken     <= 1'b0;
            s_convout <= 1'b0;
        end else begin
            clken     <= (state == ISSUE);
            s_convout <= (state == ISSUE) && tap_first;
        end
    end

    // Tag the result with the window it belongs to on entry to HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_row <= '0;
            out_col <= '0;
        end else if (state == SAT) begin
            out_row <= row;
            out_col <= col;
        end
    end

    assign busy      = state inside {ISSUE, DRAIN, SAT, HOLD};
    assign done      = (state == FIN);
    assign en_sat    = (state == SAT) || (state == HOLD);
    assign out_valid = (state == HOLD);
    assign en_mult_r = busy;
    assign signal    = img_data;
    assign weight    = w_data;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer on a 4x4 map, K=3.
// Stimulus queues expected taps/results; a monitor pops and compares.
module tb_conv_window_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done;
    logic [9:0] img_addr;
    logic [7:0] img_data;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] signal, weight;
    logic       clken, s_convout, en_sat, en_mult_r, out_valid;
    logic [7:0] out_row, out_col;

    conv_window_sequencer #(
        .IMG_W (4), .IMG_H (4), .K (3),
        .ADDR_W (10), .WADDR_W (4), .MAC_LAT (2)
    ) dut (
        .clk (clk), .reset (reset), .start (start),
        .busy (busy), .done (done),
        .img_addr (img_addr), .img_data (img_data),
        .w_addr (w_addr), .w_data (w_data),
        .signal (signal), .weight (weight),
        .clken (clken), .s_convout (s_convout),
        .en_sat (en_sat), .en_mult_r (en_mult_r),
        .out_valid (out_valid),
        .out_row (out_row), .out_col (out_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ia;
        logic [3:0] wa;
        logic       s0;
    } tap_t;

    typedef struct {
        bit         is_done;
        int         rel;
        logic [7:0] row;
        logic [7:0] col;
    } ev_t;

    tap_t tapq[$];
    ev_t  evq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_en = 0;

    // Hand-computed tap offsets for window (0,0) on a 4-wide map.
    int OFS[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int WB[4]   = '{0, 1, 4, 5};
    int WR[4]   = '{0, 0, 1, 1};
    int WC[4]   = '{0, 1, 0, 1};
    int WCYC[4] = '{13, 26, 39, 52};

    logic [7:0] img_mem[1024];
    logic [7:0] w_mem[16];
    int acc = 0;
    int prod;
    logic [9:0] prev_ia;
    logic [3:0] prev_wa;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM models.
    always @(posedge clk) begin
        img_data <= img_mem[img_addr];
        w_data   <= w_mem[w_addr];
    end

    // Behavioural MAC stage: restart on s_convout, accumulate on clken.
    assign prod = $signed(signal) * $signed(weight);
    always @(posedge clk) begin
        if (clken) acc <= s_convout ? prod : acc + prod;
    end

    // Monitor: checks taps on clken and results on out_valid/done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clken) begin
                if (tapq.size() == 0) begin
                    chk("tap_extra", 32'(prev_ia), 32'hFFFF);
                end else begin
                    tap_t e;
                    e = tapq.pop_front();
                    chk("img_addr", 32'(prev_ia), 32'(e.ia));
                    chk("w_addr", 32'(prev_wa), 32'(e.wa));
                    chk("s_convout", 32'(s_convout), 32'(e.s0));
                end
            end else if (s_convout) begin
                chk("sconv_stray", 32'(s_convout), 32'd0);
            end
            if (out_valid || done) begin
                if (evq.size() == 0) begin
                    chk("ev_extra", {30'd0, done, out_valid}, 32'd0);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("ev_kind", 32'(done), 32'(e.is_done));
                    chk("ev_cycle", 32'(cyc - t0), 32'(e.rel));
                    if (!e.is_done) begin
                        chk("out_row", 32'(out_row), 32'(e.row));
                        chk("out_col", 32'(out_col), 32'(e.col));
                        chk("hold_ctl", {29'd0, en_sat, clken, en_mult_r},
                            32'd5);
                        chk("convout", 32'(sat8(acc >>> 9)), 32'd112);
                    end
                end
            end
        end
        prev_ia = img_addr;
        prev_wa = w_addr;
    end

    task automatic push_window(input int w, input int ntaps);
        for (int t = 0; t < ntaps; t++) begin
            tap_t e;
            e.ia = 10'(WB[w] + OFS[t]);
            e.wa = 4'(t);
            e.s0 = (t == 0);
            tapq.push_back(e);
        end
    endtask

    task automatic push_ev(input bit d, input int rel,
                           input int r, input int c);
        ev_t e;
        e.is_done = d;
        e.rel     = rel;
        e.row     = 8'(r);
        e.col     = 8'(c);
        evq.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"},
            {25'd0, busy, done, clken, s_convout,
             en_sat, en_mult_r, out_valid}, 32'd0);
        chk({nm, "_rc"}, {16'd0, out_row, out_col}, 32'd0);
        chk({nm, "_addr"}, {18'd0, img_addr, w_addr}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
    endtask

    // Full 4-window pass; optionally pokes start mid-window and in FIN.
    task automatic full_pass(input bit pokes);
        for (int w = 0; w < 4; w++) begin
            push_window(w, 9);
            push_ev(1'b0, WCYC[w], WR[w], WC[w]);
        end
        push_ev(1'b1, 53, 0, 0);
        pulse_start();
        for (int i = 1; i <= 56; i++) begin
            @(negedge clk);
            start = pokes && (i == 6 || i == 53);
            if (i == 1) chk("busy_after_start", 32'(busy), 32'd1);
        end
        start = 1'b0;
        chk("busy_end", 32'(busy), 32'd0);
        chk("tapq_left", 32'(tapq.size()), 32'd0);
        chk("evq_left", 32'(evq.size()), 32'd0);
    endtask

    // Reset at tap 5 of window (0,1): only completed taps are seen.
    task automatic reset_mid();
        push_window(0, 9);
        push_ev(1'b0, 13, 0, 0);
        push_window(1, 5);
        pulse_start();
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("mid_reset");
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_tapq", 32'(tapq.size()), 32'd0);
        chk("mid_evq", 32'(evq.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) img_mem[i] = 8'd64;
        for (int i = 0; i < 16; i++) w_mem[i] = 8'd100;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_zero("reset");
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        full_pass(1'b0);
        full_pass(1'b1);
        reset_mid();
        full_pass(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
